// File: rtl/fuji_iie_pkg.sv
// Shared constants and types for the Apple IIe bus responder: mem_sel encoding,
// soft-switch address pages and the cycle-tracking state type.
package fuji_iie_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_MAIN = 3'd1;
  localparam logic [SEL_W-1:0] SEL_AUX  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_ROM  = 3'd3;
  localparam logic [SEL_W-1:0] SEL_IO   = 3'd4;
  localparam logic [SEL_W-1:0] SEL_SLOT = 3'd5;

  // Address pages (a[15:4]) of the soft-switch and language-card blocks
  localparam logic [11:0] SW_PAGE = 12'hC00;
  localparam logic [11:0] LC_PAGE = 12'hC08;

  localparam logic [ADDR_W-1:0] STACK_END = 16'h0200;
  localparam logic [ADDR_W-1:0] IO_BASE   = 16'hC000;
  localparam logic [ADDR_W-1:0] LC_BASE   = 16'hD000;
  localparam logic [ADDR_W-1:0] RB_FIRST  = 16'hC011;
  localparam logic [ADDR_W-1:0] RB_LAST   = 16'hC018;

  typedef struct packed {
    logic store80;
    logic ramrd;
    logic ramwrt;
    logic intcxrom;
    logic altzp;
    logic slotc3rom;
  } soft_sw_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } cyc_state_t;

  function automatic logic [SEL_W-1:0] ram_bank(input logic aux);
    return aux ? SEL_AUX : SEL_MAIN;
  endfunction

endpackage

// File: rtl/apple2e_bus_responder_if.sv
// 6502-side bus bundle between the CPU core (master) and the bus responder (slave).
interface apple2e_bus_responder_if;
  import fuji_iie_pkg::*;

  logic              clk_phi_0;
  logic [ADDR_W-1:0] a;
  logic              rdwr_n;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              d_oe;
  logic [SEL_W-1:0]  mem_sel;
  logic              ram_we;
  logic              lc_bank2;
  logic              store80;

  modport master (
    output clk_phi_0, a, rdwr_n, d_in,
    input  d_out, d_oe, mem_sel, ram_we, lc_bank2, store80
  );

  modport slave (
    input  clk_phi_0, a, rdwr_n, d_in,
    output d_out, d_oe, mem_sel, ram_we, lc_bank2, store80
  );

endinterface

// File: rtl/apple2e_lc_switch.sv
// Language-card state: PREWRITE, write enable, RAM read enable and $D000 bank.
// Updates only on the commit strobe of a $C08x access.
module apple2e_lc_switch #(
  parameter bit RESET_WRITE_EN = 1'b1,
  parameter bit RESET_BANK2    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit,
  input  logic [3:0] s,
  input  logic       rd,
  output logic       readram,
  output logic       write_en,
  output logic       bank2
);

  logic prewrite;

  // Write enable needs two consecutive odd reads; any even access or $C08x write breaks the pair
  always_ff @(posedge clk) begin
    if (reset) begin
      prewrite <= 1'b0;
      write_en <= RESET_WRITE_EN;
      readram  <= 1'b0;
      bank2    <= RESET_BANK2;
    end else if (commit) begin
      bank2 <= ~s[3];
      casez (s)
        4'b??00, 4'b??11: readram <= 1'b1;
        default:          readram <= 1'b0;
      endcase
      if (!s[0]) begin
        write_en <= 1'b0;
        prewrite <= 1'b0;
      end else if (rd) begin
        prewrite <= 1'b1;
        if (prewrite) write_en <= 1'b1;
      end else begin
        prewrite <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apple2e_bus_responder.sv
// Target side of the Apple IIe 6502 bus: address decode, soft switches, language card.
// Optional FUJI_IIE_SWITCH_READBACK_EN enables status reads of $C011-$C018.
module apple2e_bus_responder
  import fuji_iie_pkg::*;
#(
  parameter bit RESET_LC_WRITE_EN = 1'b1,
  parameter bit RESET_LC_BANK2    = 1'b1
) (
  input  logic                    clk_14M,
  input  logic                    reset,
  apple2e_bus_responder_if.slave  bus
);

  cyc_state_t        state, state_nxt;
  logic              phi_q;
  logic              rise_c, fall_c, load_c, commit_c;
  logic [ADDR_W-1:0] s_addr;
  logic              s_rd;
  soft_sw_t          sw;
  logic [SEL_W-1:0]  sel_q, sel_c;
  logic              we_q, we_c;
  logic              lc_readram, lc_write_en, lc_bank2;

  assign rise_c = bus.clk_phi_0 & ~phi_q;
  assign fall_c = ~bus.clk_phi_0 & phi_q;

  // Cycle tracker: a reset mid-cycle leaves us idle so the pending fall never commits
  always_ff @(posedge clk_14M) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    commit_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          load_c    = 1'b1;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (fall_c) begin
          commit_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address decode against the live bus; registered on the rise cycle
  always_comb begin
    sel_c = SEL_NONE;
    we_c  = 1'b0;
    if (bus.a < STACK_END) begin
      sel_c = ram_bank(sw.altzp);
      we_c  = ~bus.rdwr_n;
    end else if (bus.a < IO_BASE) begin
      sel_c = ram_bank(bus.rdwr_n ? sw.ramrd : sw.ramwrt);
      we_c  = ~bus.rdwr_n;
    end else if (bus.a[15:8] == 8'hC0) begin
      sel_c = SEL_IO;
    end else if (bus.a < LC_BASE) begin
      if (sw.intcxrom || (bus.a[11:8] == 4'h3 && !sw.slotc3rom)) sel_c = SEL_ROM;
      else                                                        sel_c = SEL_SLOT;
    end else if (bus.rdwr_n) begin
      sel_c = lc_readram ? ram_bank(sw.altzp) : SEL_ROM;
    end else if (lc_write_en) begin
      sel_c = ram_bank(sw.altzp);
      we_c  = 1'b1;
    end
  end

  always_ff @(posedge clk_14M) begin
    if (reset) begin
      phi_q  <= bus.clk_phi_0;
      s_addr <= '0;
      s_rd   <= 1'b1;
      sel_q  <= SEL_NONE;
      we_q   <= 1'b0;
      sw     <= '0;
    end else begin
      phi_q <= bus.clk_phi_0;
      if (load_c) begin
        s_addr <= bus.a;
        s_rd   <= bus.rdwr_n;
        sel_q  <= sel_c;
        we_q   <= we_c;
      end else if (fall_c) begin
        we_q <= 1'b0;
      end
      // Odd address sets the switch, even clears it; data is ignored
      if (commit_c && !s_rd && s_addr[15:4] == SW_PAGE) begin
        case (s_addr[3:1])
          3'd0:    sw.store80   <= s_addr[0];
          3'd1:    sw.ramrd     <= s_addr[0];
          3'd2:    sw.ramwrt    <= s_addr[0];
          3'd3:    sw.intcxrom  <= s_addr[0];
          3'd4:    sw.altzp     <= s_addr[0];
          3'd5:    sw.slotc3rom <= s_addr[0];
          default: ;
        endcase
      end
    end
  end

  apple2e_lc_switch #(
    .RESET_WRITE_EN (RESET_LC_WRITE_EN),
    .RESET_BANK2    (RESET_LC_BANK2)
  ) u_lc (
    .clk      (clk_14M),
    .reset    (reset),
    .commit   (commit_c && s_addr[15:4] == LC_PAGE),
    .s        (s_addr[3:0]),
    .rd       (s_rd),
    .readram  (lc_readram),
    .write_en (lc_write_en),
    .bank2    (lc_bank2)
  );

`ifdef FUJI_IIE_SWITCH_READBACK_EN
  logic              oe_q, oe_c, flag_c;
  logic [DATA_W-1:0] dout_q;

  always_comb begin
    oe_c   = bus.rdwr_n && bus.a >= RB_FIRST && bus.a <= RB_LAST;
    flag_c = 1'b0;
    case (bus.a[4:0])
      5'h11:   flag_c = lc_bank2;
      5'h12:   flag_c = lc_readram;
      5'h13:   flag_c = sw.ramrd;
      5'h14:   flag_c = sw.ramwrt;
      5'h15:   flag_c = sw.intcxrom;
      5'h16:   flag_c = sw.altzp;
      5'h17:   flag_c = sw.slotc3rom;
      5'h18:   flag_c = sw.store80;
      default: flag_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_14M) begin
    if (reset) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else if (load_c) begin
      oe_q   <= oe_c;
      dout_q <= oe_c ? {flag_c, 7'b0} : '0;
    end else if (fall_c) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end
  end

  assign bus.d_oe  = oe_q;
  assign bus.d_out = dout_q;
`else
  assign bus.d_oe  = 1'b0;
  assign bus.d_out = '0;
`endif

  assign bus.mem_sel  = sel_q;
  assign bus.ram_we   = we_q;
  assign bus.lc_bank2 = lc_bank2;
  assign bus.store80  = sw.store80;

endmodule
